cond_inv_d: RTL and testbench
=============================

# cond_inv_d

Parameterised conditional inverter for the datapath ALU front end. It passes operand `a` through unchanged or bitwise-inverted under control of `invert`; it is used to form B or ~B ahead of the adder for subtraction. A zero-latency combinational result feeds the adder directly. A registered, valid-qualified copy of the same result serves pipelined consumers.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1 to 64.
- `clk`  input  1  single clock; all registers update on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a`  input  WIDTH  operand.
- `invert`  input  1  1 = invert operand, 0 = pass operand through.
- `in_valid`  input  1  qualifies `a` and `invert` for the registered path.
- `y`  output  WIDTH  combinational result.
- `y_q`  output  WIDTH  registered result.
- `y_valid`  output  1  `y_q` holds a valid result.
- `y_par`  output  1  even parity of `y_q`; present only when `COND_INV_PARITY_EN` is defined.

## Operation
- Combinational path:
  - `y = invert ? ~a : a`, bitwise, full WIDTH.
  - No arithmetic, carry or sign extension.
  - `y` never depends on `clk` or `rst_n`.
- Registered path:
  - When `in_valid`=1 at a rising edge, `y_q` loads the current `y` and `y_valid` is set to 1.
  - When `in_valid`=0 at a rising edge, `y_q` holds its value and `y_valid` is cleared to 0.
- X or Z on `invert` propagates to `y`. This is not masked.

## Timing
- `y`: zero latency; it settles within the same cycle as `a` and `invert`.
- `y_q` and `y_valid`: one-cycle latency from the sampling edge.
- There is no backpressure. Every `in_valid` beat is captured.
- Back-to-back beats produce back-to-back `y_valid` pulses.
- Reset:
  - While `rst_n`=0, `y_q`=0, `y_valid`=0 and `y_par`=0, immediately and independent of `clk`.
  - `y` keeps following the inputs during reset.
- Reset deassertion is synchronised by the system. The first capture can occur on the first rising edge with `rst_n`=1.
- Reset asserted mid-stream discards the in-flight beat. `y_valid` drops immediately.

## Configuration
- `COND_INV_PARITY_EN`:
  - When defined, a `y_par` register is added. It loads `^y` together with `y_q` and holds when `y_q` holds. Its reset value is 0.
  - When undefined, the `y_par` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `cond_inv_pkg` holds:
  - `COND_INV_DEFAULT_WIDTH` = 8.
  - The typedef `cond_inv_word_t` = logic [COND_INV_DEFAULT_WIDTH-1:0].
- Sub-module `cond_inv_core` contains the purely combinational WIDTH-bit mux/inverter. `cond_inv_d` instantiates it and adds the output register, valid flag and optional parity.

## Test plan
- Pass-through: `a`=0x88, `invert`=0 -> `y`=0x88 in the same cycle. With `in_valid`=1, `y_q`=0x88 and `y_valid`=1 one cycle later.
- Invert: `a`=0x88, `invert`=1 -> `y`=0x77 in the same cycle. With `in_valid`=1, `y_q`=0x77 one cycle later. With the parity macro defined, `y_par`=0 (0x77 has six ones).
- Boundaries:
  - `a`=0x00 with `invert`=1 -> `y`=0xFF.
  - `a`=0xFF with `invert`=1 -> `y`=0x00.
  - `a`=0xA5 with `invert`=0/1 toggling every cycle -> `y_q` alternates 0xA5/0x5A with `y_valid` held at 1.
- Hold: capture 0x3C, then hold `in_valid`=0 for 3 cycles while `a` changes -> `y_q` stays 0x3C, `y_valid`=0, and `y` tracks the inputs.
- Async reset: assert `rst_n`=0 between clock edges -> `y_q`=0, `y_valid`=0 and `y_par`=0 at once, while `y` still follows `a`/`invert`. After release, the first beat is captured on the next edge.
- Width: instantiate with `WIDTH`=1 and `WIDTH`=32.
  - `a`=32'h0000_FFFF with `invert`=1 -> `y`=32'hFFFF_0000.
  - The 1-bit instance matches the truth table for all four input combinations.

Source files
------------

// File: rtl/cond_inv_pkg.sv
// Shared constants and types for the conditional inverter (B / ~B ahead of the adder).
package cond_inv_pkg;

  localparam int COND_INV_DEFAULT_WIDTH = 8;

  typedef logic [COND_INV_DEFAULT_WIDTH-1:0] cond_inv_word_t;

endpackage

// File: rtl/cond_inv_core.sv
// Purely combinational WIDTH-bit pass/invert stage.
module cond_inv_core
  import cond_inv_pkg::*;
#(
  parameter int WIDTH = COND_INV_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             invert,
  output logic [WIDTH-1:0] y
);

  // XOR with a replicated control lets an unknown invert reach every bit of y.
  assign y = a ^ {WIDTH{invert}};

endmodule

// File: rtl/cond_inv_d.sv
// Conditional inverter with a zero-latency result and a registered, valid-qualified copy.
// Optional even-parity register on the registered result: define COND_INV_PARITY_EN.
module cond_inv_d
  import cond_inv_pkg::*;
#(
  parameter int WIDTH = COND_INV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             invert,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
`ifdef COND_INV_PARITY_EN
  output logic             y_par,
`endif
  output logic             y_valid
);

  cond_inv_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .invert (invert),
    .y      (y)
  );

  // Valid-only handshake: there is no ready, so every in_valid beat seen at a rising
  // edge is captured, and y_valid is a one-cycle pulse per beat (held high for
  // back-to-back beats). y_q keeps the last captured value while y_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= in_valid;
      if (in_valid) begin
        y_q <= y;
      end
    end
  end

`ifdef COND_INV_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (in_valid) begin
      y_par <= ^y;
    end
  end
`endif

endmodule

// File: tb/tb_cond_inv_d.sv
// Self-checking bench for cond_inv_d: vector table, directed corner sequences and random beats.
module tb_cond_inv_d;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  logic [7:0]  a8, y8, yq8;
  logic        inv8, vld8, yv8;
  logic [0:0]  a1, y1, yq1;
  logic        inv1, vld1, yv1;
  logic [31:0] a32, y32, yq32;
  logic        inv32, vld32, yv32;
`ifdef COND_INV_PARITY_EN
  logic        par8, par1, par32;
`endif

  cond_inv_d #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .invert(inv8), .in_valid(vld8),
    .y(y8), .y_q(yq8),
`ifdef COND_INV_PARITY_EN
    .y_par(par8),
`endif
    .y_valid(yv8)
  );

  cond_inv_d #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .invert(inv1), .in_valid(vld1),
    .y(y1), .y_q(yq1),
`ifdef COND_INV_PARITY_EN
    .y_par(par1),
`endif
    .y_valid(yv1)
  );

  cond_inv_d #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .invert(inv32), .in_valid(vld32),
    .y(y32), .y_q(yq32),
`ifdef COND_INV_PARITY_EN
    .y_par(par32),
`endif
    .y_valid(yv32)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inversion as (all-ones minus value), parity as count of ones.
  function automatic logic [7:0] ref_y8(input logic [7:0] v, input logic inv);
    int r;
    r = inv ? (255 - int'(v)) : int'(v);
    return r[7:0];
  endfunction

  function automatic logic ref_par(input logic [63:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  // ---------------- driver ----------------
  // Called between edges: drive, check y, cross one edge, check registered outputs.
  task automatic step(input logic [7:0] av, input logic iv, input logic vv,
                      input logic [7:0] exp_y);
    a8 = av; inv8 = iv; vld8 = vv;
    #1;
    chk("y_comb", 64'(y8), 64'(exp_y));
    if (vv) exp_q.push_back(exp_y);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) held = exp_q.pop_front();
    chk("y_valid", 64'(yv8), 64'(vv));
    chk("y_q", 64'(yq8), 64'(held));
`ifdef COND_INV_PARITY_EN
    chk("y_par", 64'(par8), 64'(ref_par(64'(held))));
`endif
  endtask

  typedef struct {
    logic [7:0] a;
    logic       inv;
    logic       vld;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'h88, 1'b0, 1'b1, 8'h88};
    vecs[1] = '{8'h88, 1'b1, 1'b1, 8'h77};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'hFF};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 8'h5A};
    vecs[6] = '{8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[7] = '{8'hA5, 1'b1, 1'b1, 8'h5A};
    vecs[8] = '{8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[9] = '{8'h12, 1'b1, 1'b0, 8'hED};

    held = 8'h00;
    rst_n = 1'b0;
    a8 = 8'h5A; inv8 = 1'b1; vld8 = 1'b1;
    a1 = 1'b0; inv1 = 1'b0; vld1 = 1'b0;
    a32 = '0; inv32 = 1'b0; vld32 = 1'b0;
    #2;
    chk("rst_y_q", 64'(yq8), 64'h0);
    chk("rst_y_valid", 64'(yv8), 64'h0);
    chk("rst_y_follows", 64'(y8), 64'h0000_00A5);
`ifdef COND_INV_PARITY_EN
    chk("rst_y_par", 64'(par8), 64'h0);
`endif
    #10;  // release between edges
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors (pass, invert, 0x00/0xFF boundaries, A5/5A toggling, 3C capture)
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].a, vecs[i].inv, vecs[i].vld, vecs[i].exp_y);
    end

    // Hold: 0x3C was captured; keep in_valid low while a changes
    for (int i = 0; i < 3; i++) begin
      logic [7:0] r;
      logic       ri;
      r  = 8'($urandom_range(0, 255));
      ri = 1'($urandom_range(0, 1));
      step(r, ri, 1'b0, ref_y8(r, ri));
      chk("hold_value", 64'(yq8), 64'h3C);
    end

    // Async reset mid-cycle with a beat pending
    a8 = 8'h42; inv8 = 1'b0; vld8 = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_y_q", 64'(yq8), 64'h0);
    chk("async_y_valid", 64'(yv8), 64'h0);
`ifdef COND_INV_PARITY_EN
    chk("async_y_par", 64'(par8), 64'h0);
`endif
    chk("async_y_follows", 64'(y8), 64'h42);
    a8 = 8'h0F; inv8 = 1'b1;
    #1;
    chk("async_y_follows_inv", 64'(y8), 64'hF0);
    @(posedge clk);
    #1;
    chk("reset_held_y_valid", 64'(yv8), 64'h0);
    chk("reset_held_y_q", 64'(yq8), 64'h0);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    held = 8'h00;
    step(8'h99, 1'b1, 1'b1, 8'h66);

    // Randomized beats against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [7:0] r;
      logic       ri, rv;
      r  = 8'($urandom);
      ri = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      step(r, ri, rv, ref_y8(r, ri));
    end

    // WIDTH=1 truth table
    for (int i = 0; i < 4; i++) begin
      logic [1:0] c;
      c = 2'(i);
      a1 = c[0]; inv1 = c[1];
      #1;
      chk("w1_y", 64'(y1), 64'(c[0] != c[1]));
    end
    a1 = 1'b1; inv1 = 1'b1; vld1 = 1'b1;
    @(posedge clk);
    #1;
    chk("w1_y_q", 64'(yq1), 64'h0);
    chk("w1_y_valid", 64'(yv1), 64'h1);
    vld1 = 1'b0;

    // WIDTH=32
    a32 = 32'h0000_FFFF; inv32 = 1'b1; vld32 = 1'b1;
    #1;
    chk("w32_y", 64'(y32), 64'hFFFF_0000);
    @(posedge clk);
    #1;
    chk("w32_y_q", 64'(yq32), 64'hFFFF_0000);
    chk("w32_y_valid", 64'(yv32), 64'h1);
`ifdef COND_INV_PARITY_EN
    chk("w32_y_par", 64'(par32), 64'h0);
`endif
    for (int i = 0; i < 20; i++) begin
      logic [31:0] r;
      logic        ri;
      longint      e;
      r  = $urandom;
      ri = 1'($urandom_range(0, 1));
      e  = ri ? (64'hFFFF_FFFF - longint'(r)) : longint'(r);
      a32 = r; inv32 = ri;
      #1;
      chk("w32_rand_y", 64'(y32), 64'(e));
      @(posedge clk);
      #1;
      chk("w32_rand_y_q", 64'(yq32), 64'(e));
    end
    vld32 = 1'b0;
    @(posedge clk);
    #1;
    chk("w32_y_valid_drop", 64'(yv32), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
